// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result FIFO.
//   alu_op_e  : 3-bit ALU op codes (ALU_ADD .. ALU_EQ)
//   ENTRY_W   : width of one stored result entry (10 bits)
//   entry_t   : packed layout {ctrl, res, carry, zero, overflow}
//   is_arith  : true for op codes whose overflow flag is meaningful
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_LT  = 3'd6,
    ALU_EQ  = 3'd7
  } alu_op_e;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic [2:0] ctrl;
    logic [3:0] res;
    logic       carry;
    logic       zero;
    logic       overflow;
  } entry_t;

  // Only add and subtract produce a real signed overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_result_mem.sv
// DEPTH x ENTRY_W storage for the result FIFO.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, asynchronous (combinational) read
// The array carries no reset; validity is tracked by the FIFO occupancy.
module alu_result_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO of ALU results with a sticky arithmetic
// overflow flag and a modulo-256 push counter.
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready                 : producer handshake (in_ready = !full)
//   in_ctrl/in_res/in_carry/in_zero/in_overflow : result entry fields
//   out_valid/out_ready               : consumer handshake (out_valid = !empty)
//   out_ctrl/out_res/out_carry/out_zero/out_overflow : head entry, 0 when empty
//   count, full, empty                : occupancy status
//   clr_sticky, sticky_ovf            : sticky add/sub overflow and its clear
//   push_cnt                          : accepted results modulo 256
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_ctrl,
  input  logic [3:0]               in_res,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_ctrl,
  output logic [3:0]               out_res,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic                     clr_sticky,
  output logic                     sticky_ovf,
  output logic [7:0]               push_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_sticky;
  logic [7:0]    r_push_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  entry_t        w_wdata;
  entry_t        w_rdata;
  entry_t        w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  assign w_wdata = '{ctrl: in_ctrl, res: in_res, carry: in_carry,
                     zero: in_zero, overflow: in_overflow};

  alu_result_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Stale storage contents are masked while the FIFO is empty.
  assign w_head = w_empty ? '0 : w_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_sticky   <= 1'b0;
      r_push_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A qualifying push beats a clear in the same cycle.
      if (w_push && in_overflow && is_arith(in_ctrl)) r_sticky <= 1'b1;
      else if (clr_sticky)                            r_sticky <= 1'b0;
      if (w_push) r_push_cnt <= r_push_cnt + 8'd1;
    end
  end

  assign in_ready     = !w_full;
  assign out_valid    = !w_empty;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign sticky_ovf   = r_sticky;
  assign push_cnt     = r_push_cnt;
  assign out_ctrl     = w_head.ctrl;
  assign out_res      = w_head.res;
  assign out_carry    = w_head.carry;
  assign out_zero     = w_head.zero;
  assign out_overflow = w_head.overflow;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_ctrl;
  logic [3:0] in_res;
  logic       in_carry, in_zero, in_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_ctrl;
  logic [3:0] out_res;
  logic       out_carry, out_zero, out_overflow;
  logic [2:0] count;
  logic       full, empty;
  logic       clr_sticky;
  logic       sticky_ovf;
  logic [7:0] push_cnt;

  int n_pass  = 0;
  int n_total = 0;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_res(in_res),
    .in_carry(in_carry), .in_zero(in_zero), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_res(out_res),
    .out_carry(out_carry), .out_zero(out_zero), .out_overflow(out_overflow),
    .count(count), .full(full), .empty(empty),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .push_cnt(push_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of {ctrl,res,carry,zero,ovf} values.
  logic [9:0] mq[$];
  logic       m_sticky;
  int         m_pcnt;
  bit         m_live = 0;

  always @(posedge clk) begin
    bit do_push, do_pop;
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_pcnt   = 0;
      m_live   = 1;
    end else if (m_live) begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({in_ctrl, in_res, in_carry, in_zero, in_overflow});
      if (do_push && in_overflow && (in_ctrl <= 3'd1)) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      if (do_push) m_pcnt = (m_pcnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    logic [9:0] head;
    if (m_live) begin
      head = (mq.size() > 0) ? mq[0] : 10'd0;
      chk("count",      32'(count),      32'(mq.size()));
      chk("empty",      32'(empty),      32'(mq.size() == 0));
      chk("full",       32'(full),       32'(mq.size() == DEPTH));
      chk("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
      chk("out_valid",  32'(out_valid),  32'(mq.size() != 0));
      chk("out_fields", 32'({out_ctrl, out_res, out_carry, out_zero, out_overflow}), 32'(head));
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
      chk("push_cnt",   32'(push_cnt),   32'(m_pcnt));
    end
  end

  task automatic drive(input logic v, input logic [2:0] c, input logic [3:0] r,
                       input logic cy, input logic z, input logic o,
                       input logic ordy, input logic clr);
    in_valid = v; in_ctrl = c; in_res = r;
    in_carry = cy; in_zero = z; in_overflow = o;
    out_ready = ordy; clr_sticky = clr;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_ctrl = 0; in_res = 0; in_carry = 0; in_zero = 0;
    in_overflow = 0; out_ready = 0; clr_sticky = 0;
    repeat (3) @(negedge clk);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res",   32'(out_res),   32'd0);
    rst = 1'b0;

    // Single push appears at the head one cycle later.
    drive(1, ALU_ADD, 4'h5, 0, 0, 0, 0, 0);
    chk("p1_out_valid", 32'(out_valid), 32'd1);
    chk("p1_out_res",   32'(out_res),   32'h5);
    chk("p1_count",     32'(count),     32'd1);
    chk("p1_push_cnt",  32'(push_cnt),  32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("p1_hold_res",  32'(out_res),   32'h5);
    drain();

    // Fill, overfill attempt, drain in order.
    for (int i = 1; i <= 4; i++) drive(1, ALU_XOR, 4'(i), i[0], i[1], 0, 0, 0);
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    drive(1, ALU_AND, 4'h9, 1, 1, 1, 0, 0);
    chk("fill_ignored",  32'(count),    32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(out_res), 32'(i));
      idle(1'b1);
    end
    chk("drain_empty",   32'(empty),   32'd1);
    chk("drain_res0",    32'(out_res), 32'd0);

    // Steady push+pop at count=2 through several pointer wraps.
    drive(1, ALU_OR, 4'd10, 0, 0, 0, 0, 0);
    drive(1, ALU_OR, 4'd11, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      chk("stream_head", 32'(out_res), (k < 2) ? 32'(10 + k) : 32'(k - 2));
      drive(1, ALU_LT, 4'(k), 0, 1, 0, 1, 0);
      chk("stream_count", 32'(count), 32'd2);
    end
    drain();

    // Sticky overflow: non-arith ignored, push beats clear, clear alone.
    drive(1, ALU_XOR, 4'h3, 0, 0, 1, 0, 0);
    chk("sticky_xor", 32'(sticky_ovf), 32'd0);
    drive(1, ALU_SUB, 4'h7, 1, 0, 1, 0, 1);
    chk("sticky_set", 32'(sticky_ovf), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("sticky_clr", 32'(sticky_ovf), 32'd0);
    drive(1, ALU_ADD, 4'h8, 1, 1, 1, 1, 0);
    chk("sticky_add", 32'(sticky_ovf), 32'd1);
    drain();

    // push_cnt wrap after 256 pushes from reset.
    rst = 1'b1; idle(1'b0); rst = 1'b0;
    for (int i = 0; i < 256; i++) drive(1, 3'(i), 4'(i), 0, 0, 0, 1, 0);
    chk("pcnt_wrap", 32'(push_cnt), 32'd0);
    drain();

    // Reset dominates a push with entries in flight.
    for (int i = 0; i < 3; i++) drive(1, ALU_EQ, 4'(i + 12), 0, 0, 1, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    drive(1, ALU_ADD, 4'hF, 1, 1, 1, 1, 1);
    rst = 1'b0;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty2",   32'(empty),    32'd1);
    chk("rst_push_cnt", 32'(push_cnt), 32'd0);
    chk("rst_out_res2", 32'(out_res),  32'd0);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  ALU result presented.
REQ-005 in_ready  output  1  FIFO can accept a result this cycle.
REQ-006 in_ctrl  input  3  ALU op code that produced the result (0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 less-than, 7 equal).
REQ-007 in_res  input  4  ALU result.
REQ-008 in_carry, in_zero, in_overflow  input  1 each  ALU flags.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer takes head entry.
REQ-011 out_ctrl 3, out_res 4, out_carry 1, out_zero 1, out_overflow 1  outputs  head entry fields.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 full, empty  output  1 each  occupancy status.
REQ-014 clr_sticky  input  1  clears sticky_ovf.
REQ-015 sticky_ovf  output  1  an arithmetic overflow has been accepted since last clear.
REQ-016 push_cnt  output  8  number of accepted results, modulo 256.

Function
REQ-017 Entry SHALL be 10 bits: {ctrl, res, carry, zero, overflow}, stored unchanged.
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL equal !full, derived from registered state only, independent of out_ready.
REQ-020 out_valid SHALL equal !empty; empty = (count==0); full = (count==DEPTH).
REQ-021 Output SHALL be first-word fall-through: head entry driven combinationally from storage; a push into an empty FIFO SHALL appear at outputs with out_valid=1 the following cycle.
REQ-022 While empty, out_ctrl/out_res/out_carry/out_zero/out_overflow SHALL be driven 0.
REQ-023 While out_valid && !out_ready, all out_* fields SHALL hold stable.
REQ-024 Order SHALL be strictly first-in first-out; no entry dropped or duplicated.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-027 When full, in_valid SHALL be ignored (no push); when empty, out_ready SHALL be ignored (no pop).
REQ-028 sticky_ovf SHALL set on a push with in_overflow=1 and in_ctrl in {0,1}; overflow with other op codes SHALL not set it.
REQ-029 clr_sticky SHALL clear sticky_ovf next cycle; a qualifying push in the same cycle SHALL win (sticky_ovf=1).
REQ-030 push_cnt SHALL increment by 1 per push and wrap 255 -> 0.

Reset
REQ-031 On rst=1 at a clock edge: pointers, count, sticky_ovf, push_cnt SHALL become 0; empty=1, full=0, in_ready=1, out_valid=0, out_* data 0.
REQ-032 Reset SHALL dominate any push, pop or clr_sticky in the same cycle; in-flight entries are discarded.
REQ-033 Storage array SHALL not require reset.

Structure
REQ-034 Shared package alu_pkg SHALL hold the 3-bit op code constants (ALU_ADD..ALU_EQ) and the entry width constant (10).
REQ-035 One sub-module alu_result_mem SHALL implement DEPTH x 10 storage: synchronous write, asynchronous read.
REQ-036 Pointer, count, sticky and counter logic SHALL reside in alu_result_fifo.

Verification
REQ-037 After reset, push ctrl=0 res=4'h5 carry=0 zero=0 ovf=0 -> next cycle out_valid=1, out_res=5, count=1, push_cnt=1.
REQ-038 Push 4 entries res=1,2,3,4 with out_ready=0 -> full=1, in_ready=0; fifth in_valid ignored; drain -> outputs 1,2,3,4 in order, then empty=1, out_res=0.
REQ-039 Count=2, push and pop same cycle for 10 cycles -> count stays 2, pointers wrap, data order preserved.
REQ-040 Push ctrl=5 ovf=1 -> sticky_ovf=0; push ctrl=1 ovf=1 with clr_sticky=1 same cycle -> sticky_ovf=1; clr_sticky alone -> 0.
REQ-041 Push 256 entries with continuous pop -> push_cnt returns to 0; rst asserted at count=3 with in_valid=1 -> count=0, empty=1, push_cnt=0.
